// File: rtl/timer_if.sv
// CPU-side peripheral bus shared by the memory-mapped I/O blocks.
interface timer_if;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_data_w;
  logic [7:0]  cpu_data_r;
  logic        cpu_do_write;
  logic        data_active;

  // CPU side drives address/data/strobe and receives read data.
  modport master (
    output cpu_addr,
    output cpu_data_w,
    output cpu_do_write,
    input  cpu_data_r,
    input  data_active
  );

  // Peripheral side decodes the address and returns read data.
  modport slave (
    input  cpu_addr,
    input  cpu_data_w,
    input  cpu_do_write,
    output cpu_data_r,
    output data_active
  );
endinterface

// File: rtl/timer.sv
// Game Boy DIV/TIMA/TMA/TAC timer, including the DMG falling-edge glitches
// and the delayed TMA reload after TIMA overflow.
module timer #(
  parameter logic [15:0] BASE         = 16'hFF04,
  parameter int unsigned RELOAD_DELAY = 4
) (
  input  logic   clk,
  input  logic   reset,
  timer_if.slave bus,
  output logic   intreq_timer
);

  localparam int unsigned CNT_W  = 16;
  localparam int unsigned REG_W  = 8;
  localparam int unsigned TAC_W  = 3;
  localparam int unsigned RLD_W  = 3;

  localparam logic [15:0]      ADDR_DIV  = BASE;
  localparam logic [15:0]      ADDR_TIMA = BASE + 16'd1;
  localparam logic [15:0]      ADDR_TMA  = BASE + 16'd2;
  localparam logic [15:0]      ADDR_TAC  = BASE + 16'd3;
  localparam logic [RLD_W-1:0] RELOAD_LD = RLD_W'(RELOAD_DELAY);

  logic [CNT_W-1:0] sys_cnt_q, sys_cnt_d;
  logic [REG_W-1:0] tima_q, tima_d;
  logic [REG_W-1:0] tma_q, tma_d;
  logic [TAC_W-1:0] tac_q, tac_d;
  logic [RLD_W-1:0] reload_cnt_q, reload_cnt_d;
  logic             timer_in_q;
  logic             intreq_q, intreq_d;

  logic             wr_div, wr_tima, wr_tma, wr_tac;
  logic             sel_bit;
  logic             timer_in;
  logic             tick;
  logic [REG_W-1:0] rd_data;
  logic             rd_active;

  // Address decode for the write strobes.
  always_comb begin
    wr_div  = bus.cpu_do_write && (bus.cpu_addr == ADDR_DIV);
    wr_tima = bus.cpu_do_write && (bus.cpu_addr == ADDR_TIMA);
    wr_tma  = bus.cpu_do_write && (bus.cpu_addr == ADDR_TMA);
    wr_tac  = bus.cpu_do_write && (bus.cpu_addr == ADDR_TAC);
  end

  // Free-running system counter, TMA and TAC next values.
  always_comb begin
    sys_cnt_d = wr_div ? '0 : sys_cnt_q + CNT_W'(1);
    tma_d     = wr_tma ? bus.cpu_data_w : tma_q;
    tac_d     = wr_tac ? bus.cpu_data_w[TAC_W-1:0] : tac_q;
  end

  // Frequency select and falling-edge detect on the gated counter bit.
  always_comb begin
    sel_bit = sys_cnt_q[9];
    case (tac_q[1:0])
      2'b00:   sel_bit = sys_cnt_q[9];
      2'b01:   sel_bit = sys_cnt_q[3];
      2'b10:   sel_bit = sys_cnt_q[5];
      default: sel_bit = sys_cnt_q[7];
    endcase
    timer_in = sel_bit & tac_q[2];
    tick     = timer_in_q & ~timer_in;
  end

  // State register: all timer state, cleared asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sys_cnt_q    <= '0;
      tima_q       <= '0;
      tma_q        <= '0;
      tac_q        <= '0;
      reload_cnt_q <= '0;
      timer_in_q   <= 1'b0;
      intreq_q     <= 1'b0;
    end else begin
      sys_cnt_q    <= sys_cnt_d;
      tima_q       <= tima_d;
      tma_q        <= tma_d;
      tac_q        <= tac_d;
      reload_cnt_q <= reload_cnt_d;
      timer_in_q   <= timer_in;
      intreq_q     <= intreq_d;
    end
  end

  // Next state: IDLE when reload_cnt is zero, PENDING otherwise.
  always_comb begin
    tima_d       = tima_q;
    reload_cnt_d = reload_cnt_q;
    if (reload_cnt_q == '0) begin
      // Written value beats a coincident tick, including on overflow.
      if (wr_tima) begin
        tima_d = bus.cpu_data_w;
      end else if (tick) begin
        if (tima_q == 8'hFF) begin
          tima_d       = '0;
          reload_cnt_d = RELOAD_LD;
        end else begin
          tima_d = tima_q + REG_W'(1);
        end
      end
    end else if (reload_cnt_q == RLD_W'(1)) begin
      // Reload edge: TMA load wins over a TIMA write; a same-edge TMA write is seen.
      tima_d       = tma_d;
      reload_cnt_d = '0;
    end else begin
      // Early TIMA write cancels the pending reload and interrupt.
      if (wr_tima) begin
        tima_d       = bus.cpu_data_w;
        reload_cnt_d = '0;
      end else begin
        reload_cnt_d = reload_cnt_q - RLD_W'(1);
      end
    end
  end

  // Output decode: request pulse registered alongside the TMA load.
  always_comb begin
    intreq_d = (reload_cnt_q == RLD_W'(1));
  end

  assign intreq_timer = intreq_q;

  // Combinational read mux.
  always_comb begin
    rd_data   = 8'hFF;
    rd_active = 1'b0;
    if (bus.cpu_addr == ADDR_DIV) begin
      rd_data   = sys_cnt_q[15:8];
      rd_active = 1'b1;
    end else if (bus.cpu_addr == ADDR_TIMA) begin
      rd_data   = tima_q;
      rd_active = 1'b1;
    end else if (bus.cpu_addr == ADDR_TMA) begin
      rd_data   = tma_q;
      rd_active = 1'b1;
    end else if (bus.cpu_addr == ADDR_TAC) begin
      rd_data   = {5'b11111, tac_q};
      rd_active = 1'b1;
    end
  end

  assign bus.cpu_data_r  = rd_data;
  assign bus.data_active = rd_active;

endmodule

// File: tb/tb_timer.sv
// Directed bench for the DIV/TIMA/TMA/TAC timer.
module tb_timer;
  logic clk = 1'b0;
  logic reset;
  logic intreq_timer;
  int   vectors = 0;
  int   errors  = 0;
  int   n       = 0;
  logic [7:0] d;

  timer_if bus ();

  timer #(.BASE(16'hFF04), .RELOAD_DELAY(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus),
    .intreq_timer (intreq_timer)
  );

  always #5 clk = ~clk;

  // Advance one edge; n counts edges since reset release.
  task automatic step();
    @(posedge clk);
    #1;
    n++;
  endtask

  task automatic step_to(input int t);
    while (n < t) step();
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] v);
    bus.cpu_addr     = a;
    bus.cpu_data_w   = v;
    bus.cpu_do_write = 1'b1;
    step();
    bus.cpu_do_write = 1'b0;
    bus.cpu_addr     = 16'h0000;
  endtask

  task automatic rd(input logic [15:0] a, output logic [7:0] v);
    bus.cpu_addr = a;
    #1;
    v = bus.cpu_data_r;
  endtask

  task automatic do_reset();
    bus.cpu_do_write = 1'b0;
    bus.cpu_addr     = 16'h0000;
    bus.cpu_data_w   = 8'h00;
    reset = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    n = 0;
  endtask

  // TMA=AB, TIMA=FE, TAC=05: TIMA->FF at edge 17, overflow at 33, reload at 37.
  task automatic setup_overflow();
    do_reset();
    wr(16'hFF06, 8'hAB);
    wr(16'hFF05, 8'hFE);
    wr(16'hFF07, 8'h05);
  endtask

  task automatic test_reset();
    do_reset();
    rd(16'hFF04, d); vectors++; if (d !== 8'h00) begin errors++; $display("FAIL reset_div got %h exp 00", d); end
    rd(16'hFF05, d); vectors++; if (d !== 8'h00) begin errors++; $display("FAIL reset_tima got %h exp 00", d); end
    rd(16'hFF06, d); vectors++; if (d !== 8'h00) begin errors++; $display("FAIL reset_tma got %h exp 00", d); end
    rd(16'hFF07, d); vectors++; if (d !== 8'hF8) begin errors++; $display("FAIL reset_tac got %h exp F8", d); end
    vectors++; if (intreq_timer !== 1'b0) begin errors++; $display("FAIL reset_intreq got %b exp 0", intreq_timer); end
  endtask

  // TAC=05 at edge 1; TIMA increments at edges 17, 33, ... ; DIV becomes 01 at edge 256.
  task automatic test_prescale();
    logic [7:0] exp_t;
    do_reset();
    wr(16'hFF07, 8'h05);
    while (n < 256) begin
      step();
      exp_t = 8'((n - 1) / 16);
      rd(16'hFF05, d);
      vectors++; if (d !== exp_t) begin errors++; $display("FAIL prescale_tima n=%0d got %h exp %h", n, d, exp_t); end
      if (n == 255) begin
        rd(16'hFF04, d);
        vectors++; if (d !== 8'h00) begin errors++; $display("FAIL div_before_wrap got %h exp 00", d); end
      end
      if (n == 256) begin
        rd(16'hFF04, d);
        vectors++; if (d !== 8'h01) begin errors++; $display("FAIL div_after_wrap got %h exp 01", d); end
      end
    end
  endtask

  task automatic test_overflow();
    setup_overflow();
    step_to(32);
    rd(16'hFF05, d); vectors++; if (d !== 8'hFF) begin errors++; $display("FAIL ovf_pre got %h exp FF", d); end
    while (n < 36) begin
      step();
      rd(16'hFF05, d); vectors++; if (d !== 8'h00) begin errors++; $display("FAIL ovf_zero n=%0d got %h exp 00", n, d); end
      vectors++; if (intreq_timer !== 1'b0) begin errors++; $display("FAIL ovf_early_irq n=%0d got %b exp 0", n, intreq_timer); end
    end
    step();
    rd(16'hFF05, d); vectors++; if (d !== 8'hAB) begin errors++; $display("FAIL ovf_load got %h exp AB", d); end
    vectors++; if (intreq_timer !== 1'b1) begin errors++; $display("FAIL ovf_irq got %b exp 1", intreq_timer); end
    step();
    rd(16'hFF05, d); vectors++; if (d !== 8'hAB) begin errors++; $display("FAIL ovf_hold got %h exp AB", d); end
    vectors++; if (intreq_timer !== 1'b0) begin errors++; $display("FAIL ovf_irq_end got %b exp 0", intreq_timer); end
  endtask

  task automatic test_cancel();
    setup_overflow();
    step_to(34);
    wr(16'hFF05, 8'h33);
    while (n < 42) begin
      rd(16'hFF05, d); vectors++; if (d !== 8'h33) begin errors++; $display("FAIL cancel_tima n=%0d got %h exp 33", n, d); end
      vectors++; if (intreq_timer !== 1'b0) begin errors++; $display("FAIL cancel_irq n=%0d got %b exp 0", n, intreq_timer); end
      step();
    end
  endtask

  task automatic test_reload_edge_write();
    setup_overflow();
    step_to(36);
    wr(16'hFF05, 8'h33);
    rd(16'hFF05, d); vectors++; if (d !== 8'hAB) begin errors++; $display("FAIL edgewr_tima got %h exp AB", d); end
    vectors++; if (intreq_timer !== 1'b1) begin errors++; $display("FAIL edgewr_irq got %b exp 1", intreq_timer); end
    step();
    vectors++; if (intreq_timer !== 1'b0) begin errors++; $display("FAIL edgewr_irq_end got %b exp 0", intreq_timer); end
  endtask

  task automatic test_tma_same_edge();
    setup_overflow();
    step_to(36);
    wr(16'hFF06, 8'h5C);
    rd(16'hFF05, d); vectors++; if (d !== 8'h5C) begin errors++; $display("FAIL tmaedge_tima got %h exp 5C", d); end
    rd(16'hFF06, d); vectors++; if (d !== 8'h5C) begin errors++; $display("FAIL tmaedge_tma got %h exp 5C", d); end
    vectors++; if (intreq_timer !== 1'b1) begin errors++; $display("FAIL tmaedge_irq got %b exp 1", intreq_timer); end
  endtask

  task automatic test_div_write();
    // sys_cnt[3]=1 when DIV is written: one glitch tick.
    do_reset();
    wr(16'hFF07, 8'h05);
    step_to(11);
    wr(16'hFF04, 8'h5A);
    rd(16'hFF04, d); vectors++; if (d !== 8'h00) begin errors++; $display("FAIL divwr_div got %h exp 00", d); end
    rd(16'hFF05, d); vectors++; if (d !== 8'h00) begin errors++; $display("FAIL divwr_pre got %h exp 00", d); end
    step();
    rd(16'hFF05, d); vectors++; if (d !== 8'h01) begin errors++; $display("FAIL divwr_glitch got %h exp 01", d); end
    step_to(28);
    rd(16'hFF05, d); vectors++; if (d !== 8'h01) begin errors++; $display("FAIL divwr_once got %h exp 01", d); end
    step();
    rd(16'hFF05, d); vectors++; if (d !== 8'h02) begin errors++; $display("FAIL divwr_next got %h exp 02", d); end
    // sys_cnt[3]=0 when DIV is written: no tick, natural tick delayed.
    do_reset();
    wr(16'hFF07, 8'h05);
    step_to(4);
    wr(16'hFF04, 8'h00);
    step();
    rd(16'hFF05, d); vectors++; if (d !== 8'h00) begin errors++; $display("FAIL divwr0_none got %h exp 00", d); end
    step_to(21);
    rd(16'hFF05, d); vectors++; if (d !== 8'h00) begin errors++; $display("FAIL divwr0_late got %h exp 00", d); end
    step();
    rd(16'hFF05, d); vectors++; if (d !== 8'h01) begin errors++; $display("FAIL divwr0_tick got %h exp 01", d); end
  endtask

  task automatic test_tac_glitch();
    do_reset();
    wr(16'hFF07, 8'h05);
    step_to(9);
    wr(16'hFF07, 8'h01);
    rd(16'hFF07, d); vectors++; if (d !== 8'hF9) begin errors++; $display("FAIL tac_read got %h exp F9", d); end
    rd(16'hFF05, d); vectors++; if (d !== 8'h00) begin errors++; $display("FAIL tac_pre got %h exp 00", d); end
    while (n < 1035) begin
      step();
      rd(16'hFF05, d); vectors++; if (d !== 8'h01) begin errors++; $display("FAIL tac_glitch n=%0d got %h exp 01", n, d); end
    end
  endtask

  task automatic test_reset_pending();
    setup_overflow();
    step_to(35);
    #2;
    reset = 1'b1;
    rd(16'hFF04, d); vectors++; if (d !== 8'h00) begin errors++; $display("FAIL rstp_div got %h exp 00", d); end
    vectors++; if (bus.data_active !== 1'b1) begin errors++; $display("FAIL rstp_active got %b exp 1", bus.data_active); end
    rd(16'hFF05, d); vectors++; if (d !== 8'h00) begin errors++; $display("FAIL rstp_tima got %h exp 00", d); end
    rd(16'hFF06, d); vectors++; if (d !== 8'h00) begin errors++; $display("FAIL rstp_tma got %h exp 00", d); end
    rd(16'hFF07, d); vectors++; if (d !== 8'hF8) begin errors++; $display("FAIL rstp_tac got %h exp F8", d); end
    rd(16'hFF08, d); vectors++; if (d !== 8'hFF) begin errors++; $display("FAIL rstp_ff08 got %h exp FF", d); end
    vectors++; if (bus.data_active !== 1'b0) begin errors++; $display("FAIL rstp_inactive got %b exp 0", bus.data_active); end
    @(posedge clk);
    #1;
    reset = 1'b0;
    n = 0;
    while (n < 10) begin
      step();
      vectors++; if (intreq_timer !== 1'b0) begin errors++; $display("FAIL rstp_irq n=%0d got %b exp 0", n, intreq_timer); end
    end
    rd(16'hFF05, d); vectors++; if (d !== 8'h00) begin errors++; $display("FAIL rstp_tima_after got %h exp 00", d); end
  endtask

  initial begin
    reset            = 1'b1;
    bus.cpu_addr     = 16'h0000;
    bus.cpu_data_w   = 8'h00;
    bus.cpu_do_write = 1'b0;
    test_reset();
    test_prescale();
    test_overflow();
    test_cancel();
    test_reload_edge_write();
    test_tma_same_edge();
    test_div_write();
    test_tac_glitch();
    test_reset_pending();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
